seg_pipe_accumulator: RTL and testbench
=======================================

Name: seg_pipe_accumulator

Overview:
Parametrised, segment-pipelined signed accumulator, generalising the team's two-segment split-carry adder-accumulator. Segment width and segment count are parameters. Ripple carry is broken by one register per segment. Adds framed accumulation (first/last markers), valid-qualified bubbles, a per-frame term count and a sticky signed-overflow flag. Sits behind the MV-product datapath and sums products per output row.

Parameters:
DATA_W, 24, total accumulator/operand width in bits; must be a multiple of SEG_W.
SEG_W, 12, segment width; one pipeline stage per segment.
NSEG, DATA_W/SEG_W, derived segment count and pipeline latency (not overridden).
CNT_W, 8, width of term counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  A_i/in_first/in_last valid this cycle.
in_first  in  1  term starts a new frame; accumulation restarts from 0.
in_last  in  1  term ends the frame; result is emitted.
A_i  in  DATA_W  signed two's-complement term.
out  out  DATA_W  signed frame sum; registered, held between results.
out_valid  out  1  one-cycle pulse per frame result.
out_count  out  CNT_W  number of terms in the emitted frame, saturating at 2^CNT_W-1.
out_ovf  out  1  signed overflow occurred anywhere in the emitted frame.

Behaviour:
- Reset clears all stage registers, skew registers, carries, stage valids, accumulator segments, out, out_valid, out_count and out_ovf to 0. Effect is immediate; an in-flight frame is discarded with no out_valid.
- Operands are always accepted; there is no backpressure.
- Stage k (0..NSEG-1) owns accumulator bits [k*SEG_W +: SEG_W].
- Operand segment k and the first/last/valid tags are delayed k cycles through skew registers.
- Stage k computes: seg_sum = operand_seg + (first ? 0 : acc_seg) + carry_in.
  - carry_in is 0 for stage 0; otherwise it is the registered carry out of stage k-1 for the same term.
  - Stage k updates acc_seg and its carry register only when its delayed valid is 1.
  - Bubbles propagate as invalid slots, and term ordering is preserved.
- Arithmetic wraps modulo 2^DATA_W. The top-segment carry-out is discarded.
- Overflow, evaluated in stage NSEG-1 per valid term:
  - ovf_term = (opnd_msb == prev_acc_msb) and (result_msb != opnd_msb), with prev_acc taken as 0 when first.
  - The frame flag is set by ovf_term, cleared by first, and is sticky within the frame.
- Term counter, in stage NSEG-1: loads 1 on first, otherwise increments and saturates at all-ones.
- A term presented at input cycle t with in_last=1 produces out_valid=1 in cycle t+NSEG.
  - out equals the full frame sum (all segments, including that term's top segment), together with out_count and out_ovf.
  - The outputs update in that same cycle and hold until the next result.
- in_first and in_last in the same cycle form a single-term frame: out=A_i, out_count=1, out_ovf=0.
- Back-to-back frames are supported (last at t, first at t+1) and give consecutive out_valid pulses at t+NSEG and t+NSEG+1.
- Valid terms without a preceding first after reset accumulate onto 0.
- in_first/in_last are ignored when in_valid=0.
- Lower-segment outputs are skewed internally so that all segments of out are coherent when out_valid is high.

Test Plan:
1. Defaults, reset released; one cycle valid, first=last=1, A_i=0x000123 -> 2 cycles later out_valid=1, out=0x000123, out_count=1, out_ovf=0; out_valid is 0 the following cycle while out holds.
2. Segment carry: first A_i=0x000FFF, next cycle last A_i=0x000001 -> out=0x001000, out_count=2.
3. Signed: first -5 (0xFFFFFB), +3, last +1 -> out=0xFFFFFF, out_count=3, out_ovf=0.
4. Overflow: first 0x7FFFFF, last 0x000001 -> out=0x800000, out_ovf=1. Next frame first=last=1, A_i=1 -> out=1, out_ovf=0.
5. Bubbles and back-to-back: first 10, in_valid=0 one cycle, last 20 at cycle t, then first=last=7 at t+1 -> out=30 (count 2) at t+2, out=7 (count 1) at t+3.
6. Reset mid-frame: two terms accepted, reset pulsed before last -> outputs 0, no out_valid. Then frame first 4, last 6 -> out=10, count 2.
   - Repeat with DATA_W=32, SEG_W=8 (latency 4): carry chain 0x00FFFFFF+1 -> out=0x01000000.

Source files
------------

// File: rtl/seg_pipe_accumulator_if.sv
// Term/result bundle for seg_pipe_accumulator.
//   in_valid/in_first/in_last/A_i : one signed term per cycle, framed by first/last
//   out/out_valid/out_count/out_ovf : registered frame result, pulsed once per frame
// master = term producer / result consumer, slave = accumulator.
interface seg_pipe_accumulator_if #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_first;
  logic              in_last;
  logic [DATA_W-1:0] A_i;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_first, in_last, A_i,
    input  out, out_valid, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_first, in_last, A_i,
    output out, out_valid, out_count, out_ovf
  );
endinterface

// File: rtl/seg_pipe_accumulator.sv
// Segment-pipelined signed frame accumulator.
// The DATA_W-bit add is cut into NSEG = DATA_W/SEG_W segments; stage k adds
// segment k of a term into accumulator segment k, one cycle after stage k-1,
// so the ripple carry crosses exactly one register per segment. A term
// presented in cycle t with in_last=1 produces its frame result in cycle
// t+NSEG. NSEG must be at least 2.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears all state and outputs
//   bus   : slave side of seg_pipe_accumulator_if (terms in, results out)
module seg_pipe_accumulator #(
  parameter int DATA_W = 24,
  parameter int SEG_W  = 12,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  seg_pipe_accumulator_if.slave  bus
);

  localparam int NSEG = DATA_W / SEG_W;
  localparam int TOP  = NSEG - 1;

  // Per-stage view of the term currently in stage k. st_word carries the
  // already-summed lower segments below k and the raw operand from k upward.
  logic [DATA_W-1:0] st_word  [NSEG];
  logic              st_valid [NSEG];
  logic              st_first [NSEG];
  logic              st_last  [NSEG];
  logic              st_cin   [NSEG];
  logic [SEG_W-1:0]  st_sum   [NSEG];

  // Accumulator, one segment owned by each stage.
  logic [SEG_W-1:0]  acc_seg  [NSEG];

  // Skew registers between stage k and stage k+1.
  logic [DATA_W-1:0] sk_word  [NSEG-1];
  logic              sk_valid [NSEG-1];
  logic              sk_first [NSEG-1];
  logic              sk_last  [NSEG-1];
  logic              sk_carry [NSEG-1];

  // Frame bookkeeping held in the top stage.
  logic [CNT_W-1:0]  term_cnt;
  logic              ovf_flag;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [SEG_W-1:0]  acc_term;
    logic [SEG_W:0]    seg_total;
    logic [DATA_W-1:0] merged;

    if (k == 0) begin : g_entry
      // Framing markers only mean something on a valid slot.
      assign st_word[k]  = bus.A_i;
      assign st_valid[k] = bus.in_valid;
      assign st_first[k] = bus.in_valid & bus.in_first;
      assign st_last[k]  = bus.in_valid & bus.in_last;
      assign st_cin[k]   = 1'b0;
    end else begin : g_from_skew
      assign st_word[k]  = sk_word[k-1];
      assign st_valid[k] = sk_valid[k-1];
      assign st_first[k] = sk_first[k-1];
      assign st_last[k]  = sk_last[k-1];
      assign st_cin[k]   = sk_carry[k-1];
    end

    // A first term restarts the frame, so the old segment contributes zero.
    assign acc_term  = st_first[k] ? {SEG_W{1'b0}} : acc_seg[k];
    assign seg_total = {1'b0, st_word[k][k*SEG_W +: SEG_W]}
                     + {1'b0, acc_term}
                     + {{SEG_W{1'b0}}, st_cin[k]};
    assign st_sum[k] = seg_total[SEG_W-1:0];

    // Word handed onward: this stage's sum replaces its operand segment.
    always_comb begin
      merged = st_word[k];
      merged[k*SEG_W +: SEG_W] = st_sum[k];
    end

    // Accumulator segment advances only on valid slots; bubbles leave it alone.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc_seg[k] <= {SEG_W{1'b0}};
      end else if (st_valid[k]) begin
        acc_seg[k] <= st_sum[k];
      end
    end

    if (k < TOP) begin : g_fwd
      // Skew register: moves the term, its tags and its carry to stage k+1.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sk_word[k]  <= {DATA_W{1'b0}};
          sk_valid[k] <= 1'b0;
          sk_first[k] <= 1'b0;
          sk_last[k]  <= 1'b0;
          sk_carry[k] <= 1'b0;
        end else begin
          sk_word[k]  <= merged;
          sk_valid[k] <= st_valid[k];
          sk_first[k] <= st_first[k];
          sk_last[k]  <= st_last[k];
          sk_carry[k] <= seg_total[SEG_W];
        end
      end
    end else begin : g_top
      logic             opnd_msb;
      logic             prev_msb;
      logic             res_msb;
      logic             ovf_term;
      logic             ovf_next;
      logic [CNT_W-1:0] cnt_next;
      logic             carry_unused;

      // Sum wraps modulo 2^DATA_W; the top carry-out has no consumer.
      assign carry_unused = seg_total[SEG_W];

      // Signed overflow: like-signed addends giving an opposite-signed result.
      assign opnd_msb = st_word[k][DATA_W-1];
      assign prev_msb = st_first[k] ? 1'b0 : acc_seg[k][SEG_W-1];
      assign res_msb  = st_sum[k][SEG_W-1];
      assign ovf_term = (opnd_msb == prev_msb) && (res_msb != opnd_msb);

      // Next term count (saturating) and sticky overflow for this term.
      always_comb begin
        cnt_next = term_cnt;
        ovf_next = ovf_flag;
        if (st_first[k]) begin
          cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
          ovf_next = ovf_term;
        end else if (&term_cnt) begin
          cnt_next = term_cnt;
          ovf_next = ovf_flag | ovf_term;
        end else begin
          cnt_next = term_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          ovf_next = ovf_flag | ovf_term;
        end
      end

      // Frame state and registered result; out holds between results.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          term_cnt      <= {CNT_W{1'b0}};
          ovf_flag      <= 1'b0;
          bus.out       <= {DATA_W{1'b0}};
          bus.out_valid <= 1'b0;
          bus.out_count <= {CNT_W{1'b0}};
          bus.out_ovf   <= 1'b0;
        end else begin
          bus.out_valid <= st_valid[k] & st_last[k];
          if (st_valid[k]) begin
            term_cnt <= cnt_next;
            ovf_flag <= ovf_next;
          end
          if (st_valid[k] && st_last[k]) begin
            bus.out       <= merged;
            bus.out_count <= cnt_next;
            bus.out_ovf   <= ovf_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_pipe_accumulator.sv
// Bench for seg_pipe_accumulator: a 24/12 instance (latency 2) and a 32/8
// instance (latency 4). Drive tasks keep a full-width reference model and push
// each expected frame result with its due cycle; per-instance monitors pop and
// compare whenever out_valid is seen.
module tb_seg_pipe_accumulator;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  cnt;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  exp_t qa[$];
  exp_t qb[$];

  logic [23:0] ma_sum;
  logic [7:0]  ma_cnt;
  logic        ma_ovf;
  logic [31:0] mb_sum;
  logic [7:0]  mb_cnt;
  logic        mb_ovf;

  seg_pipe_accumulator_if #(.DATA_W(24), .CNT_W(8)) bus_a ();
  seg_pipe_accumulator_if #(.DATA_W(32), .CNT_W(8)) bus_b ();

  seg_pipe_accumulator #(.DATA_W(24), .SEG_W(12), .CNT_W(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  seg_pipe_accumulator #(.DATA_W(32), .SEG_W(8), .CNT_W(8)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for instance A.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus_a.out_valid) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL a_spurious_valid: out_valid=1 at cycle %0d with nothing expected, out=%h", cyc, bus_a.out);
      end else begin
        e = qa.pop_front();
        if (bus_a.out !== e.data[23:0] || bus_a.out_count !== e.cnt || bus_a.out_ovf !== e.ovf) begin
          failures++;
          $display("FAIL a_result: got out=%h cnt=%0d ovf=%b, want out=%h cnt=%0d ovf=%b",
                   bus_a.out, bus_a.out_count, bus_a.out_ovf, e.data[23:0], e.cnt, e.ovf);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL a_latency: result at cycle %0d, want cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus_b.out_valid) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL b_spurious_valid: out_valid=1 at cycle %0d with nothing expected, out=%h", cyc, bus_b.out);
      end else begin
        e = qb.pop_front();
        if (bus_b.out !== e.data || bus_b.out_count !== e.cnt || bus_b.out_ovf !== e.ovf) begin
          failures++;
          $display("FAIL b_result: got out=%h cnt=%0d ovf=%b, want out=%h cnt=%0d ovf=%b",
                   bus_b.out, bus_b.out_count, bus_b.out_ovf, e.data, e.cnt, e.ovf);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL b_latency: result at cycle %0d, want cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic drive_a(input logic v, input logic f, input logic l, input logic [23:0] d);
    logic [23:0] base;
    logic [23:0] nsum;
    logic        ot;
    exp_t        e;
    @(posedge clk);
    #2;
    bus_a.in_valid = v;
    bus_a.in_first = f;
    bus_a.in_last  = l;
    bus_a.A_i      = d;
    if (v) begin
      base   = f ? 24'd0 : ma_sum;
      nsum   = base + d;
      ot     = (d[23] == base[23]) && (nsum[23] != d[23]);
      ma_ovf = f ? ot : (ma_ovf | ot);
      ma_cnt = f ? 8'd1 : ((ma_cnt == 8'hFF) ? 8'hFF : ma_cnt + 8'd1);
      ma_sum = nsum;
      if (l) begin
        e.data = {8'd0, nsum};
        e.cnt  = ma_cnt;
        e.ovf  = ma_ovf;
        e.cyc  = cyc + 2;
        qa.push_back(e);
      end
    end
  endtask

  task automatic drive_b(input logic v, input logic f, input logic l, input logic [31:0] d);
    logic [31:0] base;
    logic [31:0] nsum;
    logic        ot;
    exp_t        e;
    @(posedge clk);
    #2;
    bus_b.in_valid = v;
    bus_b.in_first = f;
    bus_b.in_last  = l;
    bus_b.A_i      = d;
    if (v) begin
      base   = f ? 32'd0 : mb_sum;
      nsum   = base + d;
      ot     = (d[31] == base[31]) && (nsum[31] != d[31]);
      mb_ovf = f ? ot : (mb_ovf | ot);
      mb_cnt = f ? 8'd1 : ((mb_cnt == 8'hFF) ? 8'hFF : mb_cnt + 8'd1);
      mb_sum = nsum;
      if (l) begin
        e.data = nsum;
        e.cnt  = mb_cnt;
        e.ovf  = mb_ovf;
        e.cyc  = cyc + 4;
        qb.push_back(e);
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    qa.delete();
    qb.delete();
    ma_sum = 24'd0; ma_cnt = 8'd0; ma_ovf = 1'b0;
    mb_sum = 32'd0; mb_cnt = 8'd0; mb_ovf = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (qa.size() == 0 && qb.size() == 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus_a.out !== 24'd0 || bus_a.out_valid !== 1'b0 || bus_a.out_count !== 8'd0 || bus_a.out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_a: out=%h valid=%b cnt=%0d ovf=%b, want all zero",
               bus_a.out, bus_a.out_valid, bus_a.out_count, bus_a.out_ovf);
    end
    checks++;
    if (bus_b.out !== 32'd0 || bus_b.out_valid !== 1'b0 || bus_b.out_count !== 8'd0 || bus_b.out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_b: out=%h valid=%b cnt=%0d ovf=%b, want all zero",
               bus_b.out, bus_b.out_valid, bus_b.out_count, bus_b.out_ovf);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_single_term();
    bit ok;
    drive_a(1'b1, 1'b1, 1'b1, 24'h000123);
    drive_a(1'b0, 1'b0, 1'b0, 24'h000000);
    drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_timeout: %0d results pending, want 0", qa.size());
    end
    @(negedge clk);
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out !== 24'h000123 || bus_a.out_count !== 8'd1) begin
      failures++;
      $display("FAIL single_hold: valid=%b out=%h cnt=%0d, want valid=0 out=000123 cnt=1",
               bus_a.out_valid, bus_a.out, bus_a.out_count);
    end
  endtask

  task automatic test_segment_carry();
    bit ok;
    drive_a(1'b1, 1'b1, 1'b0, 24'h000FFF);
    drive_a(1'b1, 1'b0, 1'b1, 24'h000001);
    drive_a(1'b0, 1'b0, 1'b0, 24'h000000);
    drain(ok);
    checks++;
    if (!ok || bus_a.out !== 24'h001000 || bus_a.out_count !== 8'd2) begin
      failures++;
      $display("FAIL carry: out=%h cnt=%0d drained=%b, want out=001000 cnt=2", bus_a.out, bus_a.out_count, ok);
    end
  endtask

  task automatic test_signed();
    bit ok;
    drive_a(1'b1, 1'b1, 1'b0, 24'hFFFFFB);
    drive_a(1'b1, 1'b0, 1'b0, 24'h000003);
    drive_a(1'b1, 1'b0, 1'b1, 24'h000001);
    drive_a(1'b0, 1'b0, 1'b0, 24'h000000);
    drain(ok);
    checks++;
    if (!ok || bus_a.out !== 24'hFFFFFF || bus_a.out_count !== 8'd3 || bus_a.out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL signed: out=%h cnt=%0d ovf=%b, want out=ffffff cnt=3 ovf=0",
               bus_a.out, bus_a.out_count, bus_a.out_ovf);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    drive_a(1'b1, 1'b1, 1'b0, 24'h7FFFFF);
    drive_a(1'b1, 1'b0, 1'b1, 24'h000001);
    drive_a(1'b1, 1'b1, 1'b1, 24'h000001);
    drive_a(1'b0, 1'b0, 1'b0, 24'h000000);
    drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL overflow_timeout: %0d results pending, want 0", qa.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    drive_a(1'b1, 1'b1, 1'b0, 24'd10);
    drive_a(1'b0, 1'b1, 1'b1, 24'd99);
    drive_a(1'b1, 1'b0, 1'b1, 24'd20);
    drive_a(1'b1, 1'b1, 1'b1, 24'd7);
    drive_a(1'b0, 1'b0, 1'b0, 24'd0);
    drain(ok);
    checks++;
    if (!ok || bus_a.out !== 24'd7 || bus_a.out_count !== 8'd1) begin
      failures++;
      $display("FAIL back_to_back: out=%0d cnt=%0d drained=%b, want out=7 cnt=1", bus_a.out, bus_a.out_count, ok);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    drive_a(1'b1, 1'b1, 1'b0, 24'd100);
    drive_a(1'b1, 1'b0, 1'b0, 24'd200);
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus_a.out_valid !== 1'b0 || bus_a.out !== 24'd0 || bus_a.out_count !== 8'd0 || bus_a.out_ovf !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_idle: valid=%b out=%h cnt=%0d ovf=%b, want all zero",
                 bus_a.out_valid, bus_a.out, bus_a.out_count, bus_a.out_ovf);
      end
    end
    drive_a(1'b1, 1'b1, 1'b0, 24'd4);
    drive_a(1'b1, 1'b0, 1'b1, 24'd6);
    drive_a(1'b0, 1'b0, 1'b0, 24'd0);
    drain(ok);
    checks++;
    if (!ok || bus_a.out !== 24'd10 || bus_a.out_count !== 8'd2) begin
      failures++;
      $display("FAIL after_reset: out=%0d cnt=%0d, want out=10 cnt=2", bus_a.out, bus_a.out_count);
    end
  endtask

  task automatic test_count_saturation();
    bit ok;
    for (int i = 0; i < 300; i++) begin
      drive_a(1'b1, (i == 0), (i == 299), 24'd1);
    end
    drive_a(1'b0, 1'b0, 1'b0, 24'd0);
    drain(ok);
    checks++;
    if (!ok || bus_a.out !== 24'd300 || bus_a.out_count !== 8'hFF) begin
      failures++;
      $display("FAIL count_sat: out=%0d cnt=%0d, want out=300 cnt=255", bus_a.out, bus_a.out_count);
    end
  endtask

  task automatic test_wide_config();
    bit ok;
    drive_b(1'b1, 1'b0, 1'b0, 32'h00FFFFFF);
    drive_b(1'b1, 1'b0, 1'b1, 32'h00000001);
    drive_b(1'b1, 1'b1, 1'b0, 32'h80000000);
    drive_b(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF);
    drive_b(1'b0, 1'b0, 1'b0, 32'h00000000);
    drain(ok);
    checks++;
    if (!ok || bus_b.out !== 32'h7FFFFFFF || bus_b.out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL wide: out=%h ovf=%b drained=%b, want out=7fffffff ovf=1", bus_b.out, bus_b.out_ovf, ok);
    end
  endtask

  initial begin
    reset = 1'b1;
    cyc = 0;
    checks = 0;
    failures = 0;
    ma_sum = 24'd0; ma_cnt = 8'd0; ma_ovf = 1'b0;
    mb_sum = 32'd0; mb_cnt = 8'd0; mb_ovf = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_first = 1'b0; bus_a.in_last = 1'b0; bus_a.A_i = 24'd0;
    bus_b.in_valid = 1'b0; bus_b.in_first = 1'b0; bus_b.in_last = 1'b0; bus_b.A_i = 32'd0;
    test_reset();
    test_single_term();
    test_segment_carry();
    test_signed();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    test_count_saturation();
    test_wide_config();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
